// File: rtl/alu_issue_controller_if.sv
// Fetch handshake and ALU/register-file control bundle between the issue
// controller (master) and the instruction memory / datapath (slave).
interface alu_issue_controller_if;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] imm_ext;
  logic        alu_src_imm;
  logic [2:0]  alu_control;
  logic        reg_write;

  modport master (
    output instr_addr, instr_req,
    input  instr_valid, instr_data,
    output rs1_addr, rs2_addr, rd_addr, imm_ext,
    output alu_src_imm, alu_control, reg_write
  );

  modport slave (
    input  instr_addr, instr_req,
    output instr_valid, instr_data,
    input  rs1_addr, rs2_addr, rd_addr, imm_ext,
    input  alu_src_imm, alu_control, reg_write
  );
endinterface

// File: rtl/alu_issue_controller.sv
// Multicycle issue controller: fetch, decode, one-cycle ALU issue, writeback,
// PC advance and retirement counting.
module alu_issue_controller #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  alu_issue_controller_if.master        ctl,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal,
  output logic [31:0]                   retired_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALTED
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] retired_reg;
  logic        illegal_reg;

  logic [3:0]  opcode;
  logic        op_alu;
  logic        op_halt;
  logic        op_imm;

  assign opcode = instr_reg[31:28];

  // Legal ALU opcodes carry their ALU code in the low three bits.
  always_comb begin
    op_alu  = 1'b0;
    op_halt = 1'b0;
    op_imm  = 1'b0;
    case (opcode)
      4'd0, 4'd2, 4'd3, 4'd4, 4'd5: op_alu = 1'b1;
      4'd6, 4'd7: begin
        op_alu = 1'b1;
        op_imm = 1'b1;
      end
      4'd8:    op_halt = 1'b1;
      default: ;
    endcase
  end

  // Field outputs follow the latched word, so they change only when a new word
  // is captured, i.e. on entry to DECODE.
  assign ctl.rd_addr    = instr_reg[27:23];
  assign ctl.rs1_addr   = instr_reg[22:18];
  assign ctl.rs2_addr   = instr_reg[17:13];
  assign ctl.imm_ext    = {{19{instr_reg[12]}}, instr_reg[12:0]};
  assign ctl.instr_addr = pc_reg;

  assign busy          = (state_reg != S_IDLE) && (state_reg != S_HALTED);
  assign halted        = (state_reg == S_HALTED);
  assign illegal       = illegal_reg;
  assign retired_count = retired_reg;

  always_comb begin
    state_next      = state_reg;
    ctl.instr_req   = 1'b0;
    ctl.alu_control = 3'b000;
    ctl.alu_src_imm = 1'b0;
    ctl.reg_write   = 1'b0;
    case (state_reg)
      S_IDLE, S_HALTED: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        ctl.instr_req = 1'b1;
        if (ctl.instr_valid) state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = op_alu ? S_EXECUTE : S_HALTED;
      end
      S_EXECUTE: begin
        ctl.alu_control = opcode[2:0];
        ctl.alu_src_imm = op_imm;
        state_next      = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        ctl.reg_write = (opcode != 4'd0) && (instr_reg[27:23] != 5'd0);
        state_next    = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      pc_reg      <= PC_RESET;
      instr_reg   <= '0;
      retired_reg <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH && ctl.instr_valid)
        instr_reg <= ctl.instr_data;
      if (state_reg == S_DECODE && !op_alu && !op_halt)
        illegal_reg <= 1'b1;
      else if ((state_reg == S_IDLE || state_reg == S_HALTED) && start)
        illegal_reg <= 1'b0;
      if (state_reg == S_WRITEBACK) begin
        pc_reg <= pc_reg + PC_STEP;
        if (retired_reg != 32'hFFFF_FFFF)
          retired_reg <= retired_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_controller.sv
// Randomized self-checking bench for alu_issue_controller with a
// per-instruction behavioural reference model.
module tb_alu_issue_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_w = 1'b0;
  always #5 clk = ~clk;

  alu_issue_controller_if bus();
  alu_issue_controller_if bus_w();

  logic        busy, halted, illegal;
  logic [31:0] retired_count;
  logic        busy_w, halted_w, illegal_w;
  logic [31:0] retired_w;

  alu_issue_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctl(bus),
    .busy(busy), .halted(halted), .illegal(illegal), .retired_count(retired_count)
  );

  alu_issue_controller #(.PC_RESET(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .ctl(bus_w),
    .busy(busy_w), .halted(halted_w), .illegal(illegal_w), .retired_count(retired_w)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ret = 32'h0;

  // Reference decode: what the instruction set says each opcode means.
  function automatic void ref_decode(input logic [3:0] op, output bit legal,
                                     output bit is_halt, output logic [2:0] code);
    legal = 1'b1; is_halt = 1'b0; code = 3'b000;
    case (op)
      4'd0: code = 3'b000;
      4'd2: code = 3'b010;
      4'd3: code = 3'b011;
      4'd4: code = 3'b100;
      4'd5: code = 3'b101;
      4'd6: code = 3'b110;
      4'd7: code = 3'b111;
      4'd8: begin legal = 1'b0; is_halt = 1'b1; end
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_sext13(input logic [12:0] v);
    int val;
    val = int'(v);
    if (val >= 4096) val = val - 8192;
    return 32'(val);
  endfunction

  // Presents one word (after `stall` idle FETCH cycles) and checks the
  // whole instruction lifetime up to the next fetch request or HALTED.
  task automatic do_instr(input logic [31:0] w, input int stall);
    bit legal, is_halt;
    logic [2:0] code;
    int n, to_req, ctl_cycles, src_cycles, wr_cycles;
    logic [2:0] ctl_seen;
    logic [4:0] wr_rd;
    bit exp_wr, exp_src;
    ref_decode(w[31:28], legal, is_halt, code);
    n = 0;
    while (bus.instr_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus.instr_req !== 1'b1) begin
      failures++; $display("FAIL fetch_wait: instr_req=%b required 1", bus.instr_req);
    end
    checks++;
    if (bus.instr_addr !== m_pc) begin
      failures++; $display("FAIL fetch_addr: got %h required %h", bus.instr_addr, m_pc);
    end
    for (int i = 0; i < stall; i++) begin
      bus.instr_valid = 1'b0;
      bus.instr_data  = $urandom;
      @(negedge clk);
      checks++;
      if (bus.instr_req !== 1'b1 || bus.instr_addr !== m_pc || bus.alu_control !== 3'b000) begin
        failures++;
        $display("FAIL stall_hold: req=%b addr=%h ctl=%b required req=1 addr=%h ctl=000",
                 bus.instr_req, bus.instr_addr, bus.alu_control, m_pc);
      end
    end
    bus.instr_valid = 1'b1;
    bus.instr_data  = w;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr_data  = $urandom;
    $display("txn pc=%h word=%h stall=%0d", m_pc, w, stall);
    checks++;
    if (bus.rd_addr !== w[27:23] || bus.rs1_addr !== w[22:18] || bus.rs2_addr !== w[17:13]
        || bus.imm_ext !== ref_sext13(w[12:0])) begin
      failures++;
      $display("FAIL fields: rd=%0d rs1=%0d rs2=%0d imm=%h required rd=%0d rs1=%0d rs2=%0d imm=%h",
               bus.rd_addr, bus.rs1_addr, bus.rs2_addr, bus.imm_ext,
               w[27:23], w[22:18], w[17:13], ref_sext13(w[12:0]));
    end
    if (!legal) begin
      checks++;
      if (bus.alu_control !== 3'b000 || bus.reg_write !== 1'b0) begin
        failures++; $display("FAIL halt_decode: ctl=%b wr=%b required 000/0", bus.alu_control, bus.reg_write);
      end
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || illegal !== !is_halt || bus.alu_control !== 3'b000
          || bus.instr_req !== 1'b0 || bus.instr_addr !== m_pc || retired_count !== m_ret) begin
        failures++;
        $display("FAIL halt_state: halted=%b busy=%b illegal=%b ctl=%b req=%b addr=%h ret=%0d required 1/0/%b/000/0/%h/%0d",
                 halted, busy, illegal, bus.alu_control, bus.instr_req, bus.instr_addr,
                 retired_count, !is_halt, m_pc, m_ret);
      end
      return;
    end
    to_req = 1; ctl_cycles = 0; src_cycles = 0; wr_cycles = 0;
    ctl_seen = 3'b000; wr_rd = 5'd0;
    while (bus.instr_req !== 1'b1 && to_req < 10) begin
      if (bus.alu_control !== 3'b000) begin ctl_cycles++; ctl_seen = bus.alu_control; end
      if (bus.alu_src_imm === 1'b1) src_cycles++;
      if (bus.reg_write === 1'b1) begin wr_cycles++; wr_rd = bus.rd_addr; end
      @(negedge clk);
      to_req++;
    end
    exp_wr  = (w[31:28] != 4'd0) && (w[27:23] != 5'd0);
    exp_src = (w[31:28] == 4'd6) || (w[31:28] == 4'd7);
    if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
    m_pc = m_pc + 32'd4;
    checks++;
    if (to_req != 4) begin
      failures++; $display("FAIL latency: %0d cycles required 4", to_req);
    end
    checks++;
    if (ctl_cycles != ((code != 3'b000) ? 1 : 0) || (code != 3'b000 && ctl_seen !== code)) begin
      failures++; $display("FAIL alu_control: %0d cycles of %b required %0d of %b",
                           ctl_cycles, ctl_seen, (code != 3'b000) ? 1 : 0, code);
    end
    checks++;
    if (src_cycles != (exp_src ? 1 : 0)) begin
      failures++; $display("FAIL alu_src_imm: %0d cycles required %0d", src_cycles, exp_src ? 1 : 0);
    end
    checks++;
    if (wr_cycles != (exp_wr ? 1 : 0) || (exp_wr && wr_rd !== w[27:23])) begin
      failures++; $display("FAIL reg_write: %0d pulses rd=%0d required %0d rd=%0d",
                           wr_cycles, wr_rd, exp_wr ? 1 : 0, w[27:23]);
    end
    checks++;
    if (bus.instr_addr !== m_pc || retired_count !== m_ret || illegal !== 1'b0) begin
      failures++; $display("FAIL retire: pc=%h ret=%0d ill=%b required pc=%h ret=%0d ill=0",
                           bus.instr_addr, retired_count, illegal, m_pc, m_ret);
    end
  endtask

  function automatic logic [31:0] rand_legal_word();
    logic [3:0] ops [7] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [31:0] r;
    r = $urandom;
    return {ops[$urandom_range(0, 6)], r[27:0]};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.instr_req !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0
        || retired_count !== 32'h0 || bus.instr_addr !== 32'h0 || bus.alu_control !== 3'b000
        || bus.alu_src_imm !== 1'b0 || bus.reg_write !== 1'b0 || bus.rs1_addr !== 5'd0
        || bus.rs2_addr !== 5'd0 || bus.rd_addr !== 5'd0 || bus.imm_ext !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: req=%b busy=%b halted=%b ill=%b ret=%0d addr=%h ctl=%b src=%b wr=%b imm=%h required all zero",
               bus.instr_req, busy, halted, illegal, retired_count, bus.instr_addr,
               bus.alu_control, bus.alu_src_imm, bus.reg_write, bus.imm_ext);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.instr_req !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_wait: req=%b busy=%b required 0/0", bus.instr_req, busy);
    end
  endtask

  task automatic test_add();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (bus.instr_req !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL first_req: req=%b busy=%b required 1/1", bus.instr_req, busy);
    end
    do_instr(32'h2188_4000, 0);
  endtask

  task automatic test_addi();
    logic [31:0] r;
    r = $urandom;
    do_instr({4'd6, r[27:13], 13'h1FFF}, 0);
    checks++;
    if (bus.imm_ext !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL addi_imm: got %h required ffffffff", bus.imm_ext);
    end
  endtask

  task automatic test_stall();
    do_instr(rand_legal_word(), 5);
  endtask

  task automatic test_noop_sub_rd0();
    logic [31:0] pc0, ret0, r;
    pc0 = bus.instr_addr; ret0 = retired_count;
    r = $urandom;
    do_instr({4'd0, r[27:0]}, 0);
    r = $urandom;
    do_instr({4'd3, 5'd0, r[22:0]}, 1);
    checks++;
    if (bus.instr_addr !== pc0 + 32'd8 || retired_count !== ret0 + 32'd2) begin
      failures++; $display("FAIL noop_sub_totals: pc=%h ret=%0d required pc=%h ret=%0d",
                           bus.instr_addr, retired_count, pc0 + 32'd8, ret0 + 32'd2);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) do_instr(rand_legal_word(), $urandom_range(0, 3));
  endtask

  task automatic test_halt_restart(input logic [3:0] op);
    logic [31:0] r;
    r = $urandom;
    do_instr({op, r[27:0]}, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (illegal !== 1'b0 || halted !== 1'b0 || bus.instr_req !== 1'b1 || bus.instr_addr !== m_pc) begin
      failures++; $display("FAIL restart: ill=%b halted=%b req=%b addr=%h required 0/0/1/%h",
                           illegal, halted, bus.instr_req, bus.instr_addr, m_pc);
    end
    do_instr(rand_legal_word(), 0);
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    bus.instr_valid = 1'b1;
    bus.instr_data  = 32'h2A88_4000;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.alu_control !== 3'b010) begin
      failures++; $display("FAIL mid_execute: ctl=%b required 010", bus.alu_control);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.alu_control !== 3'b000 || bus.reg_write !== 1'b0 || busy !== 1'b0 || bus.instr_req !== 1'b0
        || bus.instr_addr !== 32'h0 || retired_count !== 32'h0 || bus.rd_addr !== 5'd0
        || bus.imm_ext !== 32'h0 || bus.alu_src_imm !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: ctl=%b wr=%b busy=%b req=%b addr=%h ret=%0d rd=%0d required reset values",
               bus.alu_control, bus.reg_write, busy, bus.instr_req, bus.instr_addr, retired_count, bus.rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 32'h0; m_ret = 32'h0;
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.reg_write === 1'b1 || busy === 1'b1) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin
      failures++; $display("FAIL abort_no_writeback: %0d active cycles required 0", wr_seen);
    end
  endtask

  task automatic test_wrap();
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    checks++;
    if (bus_w.instr_req !== 1'b1 || bus_w.instr_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_fetch: req=%b addr=%h required 1/fffffffc", bus_w.instr_req, bus_w.instr_addr);
    end
    bus_w.instr_valid = 1'b1;
    bus_w.instr_data  = 32'h2188_4000;
    @(negedge clk);
    bus_w.instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("txn wrap pc=fffffffc word=21884000");
    checks++;
    if (bus_w.instr_addr !== 32'h0 || retired_w !== 32'd1 || bus_w.instr_req !== 1'b1) begin
      failures++; $display("FAIL wrap_pc: pc=%h ret=%0d req=%b required 00000000/1/1",
                           bus_w.instr_addr, retired_w, bus_w.instr_req);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_data = 32'h0;
    bus_w.instr_valid = 1'b0;
    bus_w.instr_data = 32'h0;
    test_reset();
    test_add();
    test_addi();
    test_stall();
    test_noop_sub_rd0();
    test_random();
    test_halt_restart(4'hF);
    test_halt_restart(4'h8);
    test_halt_restart(4'h1);
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
